// File: rtl/radar_burst_controller.sv
// radar_burst_controller: multi-pulse radar timing controller.
// Issues bursts of chirps at a programmable PRI and opens a delayed,
// fixed-length ADC capture window after every chirp start.
module radar_burst_controller #(
  parameter int unsigned CNT_WIDTH         = 32,
  parameter int unsigned BURST_WIDTH       = 16,
  parameter int unsigned SR_PRI_ADDR       = 0,
  parameter int unsigned SR_ADC_DELAY_ADDR = 1,
  parameter int unsigned SR_ADC_LEN_ADDR   = 2,
  parameter int unsigned SR_BURST_ADDR     = 3,
  parameter int unsigned SR_CTRL_ADDR      = 4,
  parameter int unsigned PRI_INIT          = 245760,
  parameter int unsigned ADC_DELAY_INIT    = 0,
  parameter int unsigned ADC_LEN_INIT      = 510,
  parameter int unsigned BURST_INIT        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic                   trigger,
  input  logic                   awg_ready,
  input  logic                   awg_active,
  input  logic                   awg_done,
  output logic                   awg_init,
  output logic                   awg_enable,
  output logic                   adc_enable,
  output logic [BURST_WIDTH-1:0] pulse_index,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   error
);

  localparam int unsigned AGE_WIDTH = CNT_WIDTH + 1;
  localparam int unsigned PRI_MIN   = 4;
  // The pulse ends two cycles before the PRI boundary so that the
  // ARM and INIT cycles land the next awg_init exactly PRI cycles later.
  localparam int unsigned PRI_LEAD  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_INIT  = 3'd2,
    S_CHIRP = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // settings-side registers
  logic [CNT_WIDTH-1:0]   r_pri_set;
  logic [CNT_WIDTH-1:0]   r_dly_set;
  logic [CNT_WIDTH-1:0]   r_len_set;
  logic [BURST_WIDTH-1:0] r_burst_set;
  logic [1:0]             r_mode;

  // working (shadow) registers, loaded on IDLE->ARM
  logic [CNT_WIDTH-1:0]   r_pri;
  logic [CNT_WIDTH-1:0]   r_dly;
  logic [CNT_WIDTH-1:0]   r_len;
  logic [BURST_WIDTH-1:0] r_burst;

  logic                   r_trig_d;
  logic                   r_trig_rise;
  logic [CNT_WIDTH-1:0]   r_pri_cnt;
  logic [AGE_WIDTH-1:0]   r_adc_age;

  logic                   r_awg_init;
  logic                   r_awg_en;
  logic                   r_adc_en;
  logic [BURST_WIDTH-1:0] r_pulse_idx;
  logic                   r_busy;
  logic                   r_burst_done;
  logic                   r_error;

  logic                   w_wr_pri;
  logic                   w_wr_dly;
  logic                   w_wr_len;
  logic                   w_wr_burst;
  logic                   w_wr_ctrl;
  logic [CNT_WIDTH-1:0]   w_pri_new;
  logic [CNT_WIDTH-1:0]   w_dly_new;
  logic [CNT_WIDTH-1:0]   w_len_new;
  logic [BURST_WIDTH-1:0] w_burst_new;
  logic [1:0]             w_mode_new;
  logic [CNT_WIDTH-1:0]   w_pri_ld;
  logic [BURST_WIDTH-1:0] w_burst_ld;
  logic                   w_soft;
  logic                   w_abort;
  logic                   w_err_clr;
  logic                   w_start;
  logic                   w_shadow_ld;
  logic                   w_pri_zero;
  logic                   w_pri_due;
  logic                   w_last;
  logic                   w_pulse_fin;
  logic                   w_timeout;
  logic                   w_active;
  logic [AGE_WIDTH-1:0]   w_adc_age;
  logic [AGE_WIDTH-1:0]   w_win_end;
  logic                   w_win;

  logic                   w_awg_init_nxt;
  logic                   w_awg_en_nxt;
  logic                   w_adc_en_nxt;
  logic [BURST_WIDTH-1:0] w_pulse_idx_nxt;
  logic                   w_busy_nxt;
  logic                   w_burst_done_nxt;
  logic                   w_error_nxt;

  // settings decode; a write in the same cycle as a load is seen by the load
  assign w_wr_pri    = set_stb && (set_addr == 8'(SR_PRI_ADDR));
  assign w_wr_dly    = set_stb && (set_addr == 8'(SR_ADC_DELAY_ADDR));
  assign w_wr_len    = set_stb && (set_addr == 8'(SR_ADC_LEN_ADDR));
  assign w_wr_burst  = set_stb && (set_addr == 8'(SR_BURST_ADDR));
  assign w_wr_ctrl   = set_stb && (set_addr == 8'(SR_CTRL_ADDR));

  assign w_pri_new   = w_wr_pri   ? set_data[CNT_WIDTH-1:0]   : r_pri_set;
  assign w_dly_new   = w_wr_dly   ? set_data[CNT_WIDTH-1:0]   : r_dly_set;
  assign w_len_new   = w_wr_len   ? set_data[CNT_WIDTH-1:0]   : r_len_set;
  assign w_burst_new = w_wr_burst ? set_data[BURST_WIDTH-1:0] : r_burst_set;
  assign w_mode_new  = w_wr_ctrl  ? set_data[1:0]             : r_mode;

  assign w_soft      = w_wr_ctrl && set_data[2];
  assign w_abort     = w_wr_ctrl && set_data[3];
  assign w_err_clr   = w_wr_ctrl && set_data[4];

  assign w_pri_ld    = (w_pri_new < CNT_WIDTH'(PRI_MIN)) ? CNT_WIDTH'(PRI_MIN) : w_pri_new;
  assign w_burst_ld  = (w_burst_new == '0) ? BURST_WIDTH'(1) : w_burst_new;

  assign w_start     = ((w_mode_new == 2'd1) && (r_trig_rise || w_soft)) ||
                       (w_mode_new == 2'd2);
  assign w_shadow_ld = (r_state == S_IDLE) && (w_state_nxt == S_ARM);

  assign w_pri_zero  = (r_pri_cnt == '0);
  assign w_pri_due   = (r_pri_cnt <= CNT_WIDTH'(1));
  assign w_last      = (r_pulse_idx == (r_burst - BURST_WIDTH'(1)));

  // ADC window: age counts cycles since awg_init (0 in the INIT cycle);
  // ADC_LEN = 0 makes the range empty, so no window opens.
  assign w_active    = (r_state == S_INIT) || (r_state == S_CHIRP) || (r_state == S_WAIT);
  assign w_adc_age   = (r_state == S_INIT) ? '0 : r_adc_age;
  assign w_win_end   = {1'b0, r_dly} + {1'b0, r_len};
  assign w_win       = w_active && (w_adc_age >= {1'b0, r_dly}) && (w_adc_age < w_win_end);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic and pulse/timeout event decode
  always_comb begin
    w_state_nxt = r_state;
    w_pulse_fin = 1'b0;
    w_timeout   = 1'b0;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_state_nxt = S_ARM;
          end
        end
        S_ARM: begin
          if (awg_ready && !awg_active) begin
            w_state_nxt = S_INIT;
          end
        end
        S_INIT: begin
          w_state_nxt = S_CHIRP;
        end
        S_CHIRP: begin
          if (awg_done) begin
            if (w_pri_due) begin
              w_pulse_fin = 1'b1;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end else if (w_pri_zero) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (w_pri_due) begin
            w_pulse_fin = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
      if (w_pulse_fin) begin
        w_state_nxt = w_last ? S_IDLE : S_ARM;
      end
    end
  end

  // next values of the registered outputs
  always_comb begin
    w_awg_init_nxt   = (w_state_nxt == S_INIT);
    w_awg_en_nxt     = (w_state_nxt == S_CHIRP);
    w_adc_en_nxt     = w_win && !w_abort;
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_burst_done_nxt = w_pulse_fin && w_last;
    w_pulse_idx_nxt  = r_pulse_idx;
    w_error_nxt      = r_error;
    if (w_abort || w_timeout || (w_pulse_fin && w_last)) begin
      w_pulse_idx_nxt = '0;
    end else if (w_pulse_fin) begin
      w_pulse_idx_nxt = r_pulse_idx + BURST_WIDTH'(1);
    end
    if (w_err_clr) begin
      w_error_nxt = 1'b0;
    end
    if (w_timeout) begin
      w_error_nxt = 1'b1;
    end
  end

  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awg_init   <= 1'b0;
      r_awg_en     <= 1'b0;
      r_adc_en     <= 1'b0;
      r_pulse_idx  <= '0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_awg_init   <= w_awg_init_nxt;
      r_awg_en     <= w_awg_en_nxt;
      r_adc_en     <= w_adc_en_nxt;
      r_pulse_idx  <= w_pulse_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_burst_done <= w_burst_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // settings registers and trigger edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pri_set   <= CNT_WIDTH'(PRI_INIT);
      r_dly_set   <= CNT_WIDTH'(ADC_DELAY_INIT);
      r_len_set   <= CNT_WIDTH'(ADC_LEN_INIT);
      r_burst_set <= BURST_WIDTH'(BURST_INIT);
      r_mode      <= 2'd0;
      r_trig_d    <= 1'b0;
      r_trig_rise <= 1'b0;
    end else begin
      r_pri_set   <= w_pri_new;
      r_dly_set   <= w_dly_new;
      r_len_set   <= w_len_new;
      r_burst_set <= w_burst_new;
      r_mode      <= w_mode_new;
      r_trig_d    <= trigger;
      r_trig_rise <= trigger && !r_trig_d;
    end
  end

  // shadow registers, updated only when a burst is armed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pri   <= CNT_WIDTH'(PRI_INIT);
      r_dly   <= CNT_WIDTH'(ADC_DELAY_INIT);
      r_len   <= CNT_WIDTH'(ADC_LEN_INIT);
      r_burst <= BURST_WIDTH'(BURST_INIT);
    end else if (w_shadow_ld) begin
      r_pri   <= w_pri_ld;
      r_dly   <= w_dly_new;
      r_len   <= w_len_new;
      r_burst <= w_burst_ld;
    end
  end

  // PRI down-counter and ADC age counter, both restarted by INIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pri_cnt <= '0;
      r_adc_age <= '0;
    end else if (r_state == S_INIT) begin
      r_pri_cnt <= r_pri - CNT_WIDTH'(PRI_LEAD);
      r_adc_age <= AGE_WIDTH'(1);
    end else if ((r_state == S_CHIRP) || (r_state == S_WAIT)) begin
      if (!w_pri_zero) begin
        r_pri_cnt <= r_pri_cnt - CNT_WIDTH'(1);
      end
      if (r_adc_age != '1) begin
        r_adc_age <= r_adc_age + AGE_WIDTH'(1);
      end
    end
  end

  assign awg_init    = r_awg_init;
  assign awg_enable  = r_awg_en;
  assign adc_enable  = r_adc_en;
  assign pulse_index = r_pulse_idx;
  assign busy        = r_busy;
  assign burst_done  = r_burst_done;
  assign error       = r_error;

endmodule

// File: tb/tb_radar_burst_controller.sv
// Directed testbench for radar_burst_controller with a simple AWG model.
module tb_radar_burst_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        trigger;
  logic        awg_ready;
  logic        awg_active;
  logic        awg_done = 1'b0;
  logic        awg_init;
  logic        awg_enable;
  logic        adc_enable;
  logic [15:0] pulse_index;
  logic        busy;
  logic        burst_done;
  logic        error;

  radar_burst_controller dut (
    .clk         (clk),
    .reset       (reset),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .trigger     (trigger),
    .awg_ready   (awg_ready),
    .awg_active  (awg_active),
    .awg_done    (awg_done),
    .awg_init    (awg_init),
    .awg_enable  (awg_enable),
    .adc_enable  (adc_enable),
    .pulse_index (pulse_index),
    .busy        (busy),
    .burst_done  (burst_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // AWG model: one-cycle awg_done a fixed delay after each awg_init
  int   done_at  = -1;
  int   done_dly = 40;
  logic withhold = 1'b0;
  always @(negedge clk) if (awg_init && !withhold) done_at = cyc + done_dly;
  always @(posedge clk) begin
    #1;
    awg_done = (cyc == done_at);
  end

  // event monitor
  int   clr_req = 0, clr_seen = 0;
  int   n_init = 0, n_win = 0, n_bdone = 0, adc_at_init = 0;
  int   err_cyc = -1, en_rise = -1, en_fall = -1, cur_start = 0;
  int   init_cyc[16];
  int   init_pidx[16];
  int   win_start[16];
  int   win_len[16];
  logic adc_q = 1'b0, en_q = 1'b0, err_q = 1'b0;

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      n_init = 0; n_win = 0; n_bdone = 0; adc_at_init = 0;
      err_cyc = -1; en_rise = -1; en_fall = -1;
    end
    if (awg_init) begin
      if (n_init < 16) begin
        init_cyc[n_init]  = cyc;
        init_pidx[n_init] = int'(pulse_index);
      end
      n_init++;
      if (adc_enable) adc_at_init++;
    end
    if (adc_enable && !adc_q) cur_start = cyc;
    if (!adc_enable && adc_q) begin
      if (n_win < 16) begin
        win_start[n_win] = cur_start;
        win_len[n_win]   = cyc - cur_start;
      end
      n_win++;
    end
    if (burst_done) n_bdone++;
    if (error && !err_q) err_cyc = cyc;
    if (awg_enable && !en_q && en_rise < 0) en_rise = cyc;
    if (!awg_enable && en_q && en_fall < 0) en_fall = cyc;
    adc_q = adc_enable;
    en_q  = awg_enable;
    err_q = error;
  end

  task automatic clr();
    clr_req++;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    @(posedge clk); #1;
    set_stb = 1'b1; set_addr = 8'(a); set_data = 32'(d);
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic wait_inits(input int n, input int max_cyc);
    int k;
    k = 0;
    while (n_init < n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check("wait_init", int'(n_init >= n), 1);
  endtask

  int trig_cyc;

  initial begin
    reset = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    trigger = 1'b0; awg_ready = 1'b1; awg_active = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", int'({awg_init, awg_enable, adc_enable, busy, burst_done, error}), 0);
    check("rst_pidx", int'(pulse_index), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // single burst via trigger input: PRI=100, BURST=3, DELAY=10, LEN=20
    wr(0, 100); wr(1, 10); wr(2, 20); wr(3, 3); wr(4, 1);
    clr();
    @(posedge clk); #1 trigger = 1'b1; trig_cyc = cyc;
    repeat (5) @(posedge clk);
    #1 trigger = 1'b0;
    wait_inits(3, 400);
    repeat (120) @(negedge clk);
    check("trig_to_init", init_cyc[0] - trig_cyc, 3);
    check("t1_n_init", n_init, 3);
    check("t1_pri01", init_cyc[1] - init_cyc[0], 100);
    check("t1_pri12", init_cyc[2] - init_cyc[1], 100);
    check("t1_n_win", n_win, 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_pidx", init_pidx[i], i);
      check("t1_win_off", win_start[i] - init_cyc[i], 11);
      check("t1_win_len", win_len[i], 20);
    end
    check("t1_en_rise", en_rise - init_cyc[0], 1);
    check("t1_en_fall", en_fall - init_cyc[0], 41);
    check("t1_bdone", n_bdone, 1);
    check("t1_busy", int'(busy), 0);
    check("t1_pidx_end", int'(pulse_index), 0);
    check("t1_error", int'(error), 0);

    // window truncation: PRI=50, DELAY=40, LEN=30, soft trigger
    wr(0, 50); wr(1, 40); wr(2, 30); wr(3, 2);
    clr();
    wr(4, 1 | 4);
    wait_inits(2, 200);
    repeat (70) @(negedge clk);
    check("t2_n_win", n_win, 2);
    check("t2_len0", win_len[0], 9);
    check("t2_len1", win_len[1], 9);
    check("t2_off0", win_start[0] - init_cyc[0], 41);
    check("t2_adc_at_init", adc_at_init, 0);
    check("t2_bdone", n_bdone, 1);

    // AWG timeout with awg_done withheld, PRI=64
    wr(0, 64); wr(1, 0); wr(2, 5); wr(3, 1);
    withhold = 1'b1;
    clr();
    wr(4, 1 | 4);
    wait_inits(1, 50);
    repeat (80) @(negedge clk);
    check("t3_err_at", err_cyc - init_cyc[0], 64);
    check("t3_en_fall", en_fall - init_cyc[0], 64);
    check("t3_error", int'(error), 1);
    check("t3_awg_en", int'(awg_enable), 0);
    check("t3_busy", int'(busy), 0);
    check("t3_bdone", n_bdone, 0);
    withhold = 1'b0;
    wr(4, 16);
    @(negedge clk);
    check("t3_err_clr", int'(error), 0);

    // continuous mode, BURST=2, then mode 0 during the second burst
    wr(0, 60); wr(1, 10); wr(2, 20); wr(3, 2);
    clr();
    wr(4, 2);
    wait_inits(4, 400);
    repeat (20) @(negedge clk);
    wr(4, 0);
    repeat (150) @(negedge clk);
    check("t4_n_init", n_init, 4);
    check("t4_pri01", init_cyc[1] - init_cyc[0], 60);
    check("t4_gap", init_cyc[2] - init_cyc[1], 61);
    check("t4_pri23", init_cyc[3] - init_cyc[2], 60);
    check("t4_pidx3", init_pidx[3], 1);
    check("t4_bdone", n_bdone, 2);
    check("t4_busy", int'(busy), 0);

    // abort in CHIRP of the second pulse
    wr(0, 100); wr(3, 3);
    clr();
    wr(4, 1 | 4);
    wait_inits(2, 300);
    repeat (15) @(negedge clk);
    check("t5_pre_pidx", int'(pulse_index), 1);
    check("t5_pre_act", int'({awg_enable, adc_enable, busy}), 7);
    wr(4, 8 | 1);
    @(negedge clk);
    check("t5_abort_outs", int'({awg_init, awg_enable, adc_enable, busy, burst_done, error}), 0);
    check("t5_abort_pidx", int'(pulse_index), 0);
    repeat (200) @(negedge clk);
    check("t5_n_init", n_init, 2);
    check("t5_bdone", n_bdone, 0);

    // asynchronous reset in WAIT of the second pulse with the window open
    wr(1, 40); wr(2, 30);
    clr();
    wr(4, 1 | 4);
    wait_inits(2, 300);
    repeat (45) @(negedge clk);
    check("t6_pre_pidx", int'(pulse_index), 1);
    check("t6_pre_act", int'({awg_enable, adc_enable, busy}), 3);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("t6_rst_outs", int'({awg_init, awg_enable, adc_enable, busy, burst_done, error}), 0);
    check("t6_rst_pidx", int'(pulse_index), 0);
    @(posedge clk); #1 reset = 1'b0;

    // shadowing: PRI written mid-burst applies to the next burst
    wr(0, 100); wr(1, 10); wr(2, 20); wr(3, 2);
    clr();
    wr(4, 1 | 4);
    wait_inits(1, 50);
    repeat (20) @(negedge clk);
    wr(0, 200);
    wait_inits(2, 200);
    repeat (120) @(negedge clk);
    wr(4, 1 | 4);
    wait_inits(4, 600);
    repeat (220) @(negedge clk);
    check("t7_pri_old", init_cyc[1] - init_cyc[0], 100);
    check("t7_pri_new", init_cyc[3] - init_cyc[2], 200);
    check("t7_bdone", n_bdone, 2);

    // PRI=1 clamps to 4
    done_dly = 1;
    wr(0, 1);
    clr();
    wr(4, 1 | 4);
    wait_inits(2, 50);
    repeat (10) @(negedge clk);
    check("t7_pri_clamp", init_cyc[1] - init_cyc[0], 4);
    check("t7_clamp_bdone", n_bdone, 1);
    check("t7_clamp_err", int'(error), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
